// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 VGA timing constants and receiver state type.
// Used by both the timing generator and vga_sync_receiver.
//   H_* / V_*        : default porch, sync and visible sizes (pixels / lines)
//   H_TOTAL, V_TOTAL : full line length and full frame height
//   H_START, V_START : first visible hcnt / vcnt (counting from the sync fall)
//   rx_state_t       : receiver lock FSM states
package vga_timing_pkg;

   localparam int unsigned H_VISIBLE   = 640;
   localparam int unsigned H_FRONT     = 16;
   localparam int unsigned H_SYNC      = 96;
   localparam int unsigned H_BACK      = 48;
   localparam int unsigned V_VISIBLE   = 480;
   localparam int unsigned V_FRONT     = 10;
   localparam int unsigned V_SYNC      = 2;
   localparam int unsigned V_BACK      = 33;
   localparam int unsigned LOCK_FRAMES = 2;

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_START = H_SYNC + H_BACK;
   localparam int unsigned V_START = V_SYNC + V_BACK;

   typedef enum logic [1:0] {
      SEARCH,
      TRAIN,
      LOCKED
   } rx_state_t;

endpackage

// File: rtl/vga_axis_checker.sv
// vga_axis_checker: one timing axis (horizontal or vertical) of the VGA receiver.
// Counts enable events, restarts at a sync fall and checks the period and the
// sync low width.
//   clk, reset : clock, synchronous active-high reset
//   en         : count enable (pixel strobe for H, hsync fall for V)
//   sync_fall  : sync falling edge seen (may arrive between enables)
//   sync_rise  : sync rising edge seen (may arrive between enables)
//   count      : position of the element being processed this enable
//   err        : single-cycle period or sync-width error, qualified by en
module vga_axis_checker
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL  = H_TOTAL,
   parameter int unsigned SYNC_W = H_SYNC,
   parameter int unsigned CW     = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          sync_fall,
   input  logic          sync_rise,
   output logic [CW-1:0] count,
   output logic          err
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW:0]   TOTAL_L = (CW+1)'(TOTAL);
   localparam logic [CW:0]   SYNC_L  = (CW+1)'(SYNC_W);

   logic [CW-1:0] cnt_q;
   logic          fall_pend_q;
   logic          rise_pend_q;
   logic          fall_eff;
   logic          rise_eff;
   logic [CW:0]   len;

   // A sync edge that lands between enables is held until the next enable,
   // so a vsync fall takes effect on the hsync fall coincident with or after it.
   always_comb begin
      fall_eff = en & (sync_fall | fall_pend_q);
      rise_eff = en & (sync_rise | rise_pend_q);
      len      = {1'b0, cnt_q} + 1'b1;
      if (fall_eff) begin
         count = '0;
      end else if (en && (cnt_q != CNT_MAX)) begin
         count = cnt_q + 1'b1;
      end else begin
         count = cnt_q;
      end
      // A saturated counter gives len = 2^CW, which never matches TOTAL.
      err = (fall_eff && (len != TOTAL_L)) || (rise_eff && (len != SYNC_L));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         fall_pend_q <= 1'b0;
         rise_pend_q <= 1'b0;
      end else begin
         cnt_q       <= count;
         fall_pend_q <= (fall_pend_q | sync_fall) & ~en;
         rise_pend_q <= (rise_pend_q | sync_rise) & ~en;
      end
   end

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: samples a VGA stream at the pixel strobe, checks timing,
// locks after LOCK_FRAMES clean frames and emits one valid pixel per visible
// position with recovered x/y.
//   clk, reset              : clock, synchronous active-high reset
//   pix_en                  : pixel-rate strobe
//   hsync_in, vsync_in      : active-low syncs
//   red_in/green_in/blue_in : 4-bit colour
//   locked                  : timing verified
//   x, y, pixel_r/g/b       : recovered position and colour, qualified by pixel_valid
//   frame_start             : pulse on each vsync fall
//   timing_error            : pulse on a timing violation (TRAIN / LOCKED only)
// Optional (macro VGA_RX_CHECKSUM_EN): frame_checksum, checksum_valid give a
// 16-bit wrap-around sum of the previous locked frame's {r,g,b} pixels.
module vga_sync_receiver #(
   parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
   parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
   parameter int unsigned LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [3:0] red_in,
   input  logic [3:0] green_in,
   input  logic [3:0] blue_in,
   output logic       locked,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pixel_valid,
   output logic [3:0] pixel_r,
   output logic [3:0] pixel_g,
   output logic [3:0] pixel_b,
   output logic       frame_start,
   output logic       timing_error
`ifdef VGA_RX_CHECKSUM_EN
   ,
   output logic [15:0] frame_checksum,
   output logic        checksum_valid
`endif
);

   import vga_timing_pkg::*;

   localparam int unsigned LINE_LEN  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned FRAME_LEN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] X_FIRST = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] X_LAST  = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
   localparam logic [9:0] Y_FIRST = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] Y_LAST  = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
   localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

   // Input sampling: current and previous registered syncs for edge detection.
   logic       hs_q, hs_p, vs_q, vs_p;
   logic [3:0] r_q, g_q, b_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q <= 1'b1;
         hs_p <= 1'b1;
         vs_q <= 1'b1;
         vs_p <= 1'b1;
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
      end else if (pix_en) begin
         hs_q <= hsync_in;
         hs_p <= hs_q;
         vs_q <= vsync_in;
         vs_p <= vs_q;
         r_q  <= red_in;
         g_q  <= green_in;
         b_q  <= blue_in;
      end
   end

   logic       hfall, hrise, vfall, vrise;
   logic       hfall_en;
   logic [9:0] hpos, vpos;
   logic       herr, verr, err;
   logic       visible;

   always_comb begin
      hfall    = pix_en & hs_p & ~hs_q;
      hrise    = pix_en & ~hs_p & hs_q;
      vfall    = pix_en & vs_p & ~vs_q;
      vrise    = pix_en & ~vs_p & vs_q;
      hfall_en = hfall;
   end

   vga_axis_checker #(
      .TOTAL  (LINE_LEN),
      .SYNC_W (H_SYNC),
      .CW     (10)
   ) u_h_axis (
      .clk       (clk),
      .reset     (reset),
      .en        (pix_en),
      .sync_fall (hfall),
      .sync_rise (hrise),
      .count     (hpos),
      .err       (herr)
   );

   vga_axis_checker #(
      .TOTAL  (FRAME_LEN),
      .SYNC_W (V_SYNC),
      .CW     (10)
   ) u_v_axis (
      .clk       (clk),
      .reset     (reset),
      .en        (hfall_en),
      .sync_fall (vfall),
      .sync_rise (vrise),
      .count     (vpos),
      .err       (verr)
   );

   rx_state_t  state_q;
   logic [7:0] good_q;
   logic       pix_ok;

   // hpos/vpos are the position of the sample held in r_q/g_q/b_q.
   always_comb begin
      err     = herr | verr;
      visible = (hpos >= X_FIRST) && (hpos <= X_LAST) && (vpos >= Y_FIRST) && (vpos <= Y_LAST);
      pix_ok  = pix_en & visible & (state_q == LOCKED) & ~err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SEARCH;
         good_q       <= '0;
         locked       <= 1'b0;
         timing_error <= 1'b0;
         frame_start  <= 1'b0;
         pixel_valid  <= 1'b0;
         x            <= '0;
         y            <= '0;
         pixel_r      <= '0;
         pixel_g      <= '0;
         pixel_b      <= '0;
      end else begin
         timing_error <= 1'b0;
         frame_start  <= 1'b0;
         pixel_valid  <= 1'b0;
         if (pix_en) begin
            frame_start <= vfall;
            unique case (state_q)
               SEARCH: begin
                  if (vfall) begin
                     state_q <= TRAIN;
                     good_q  <= '0;
                  end
               end
               TRAIN: begin
                  if (err) begin
                     state_q      <= SEARCH;
                     good_q       <= '0;
                     timing_error <= 1'b1;
                  end else if (vfall) begin
                     good_q <= good_q + 8'd1;
                     if (good_q + 8'd1 >= LOCK_N) begin
                        state_q <= LOCKED;
                        locked  <= 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (err) begin
                     state_q      <= SEARCH;
                     good_q       <= '0;
                     locked       <= 1'b0;
                     timing_error <= 1'b1;
                  end
               end
               default: begin
                  state_q <= SEARCH;
                  good_q  <= '0;
                  locked  <= 1'b0;
               end
            endcase
            if (pix_ok) begin
               pixel_valid <= 1'b1;
               x           <= hpos - X_FIRST;
               y           <= vpos - Y_FIRST;
               pixel_r     <= r_q;
               pixel_g     <= g_q;
               pixel_b     <= b_q;
            end
         end
      end
   end

`ifdef VGA_RX_CHECKSUM_EN
   logic [15:0] sum_q;

   // The accumulator restarts at every vsync fall; only a locked boundary publishes.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q          <= '0;
         frame_checksum <= '0;
         checksum_valid <= 1'b0;
      end else begin
         checksum_valid <= 1'b0;
         if (vfall) begin
            sum_q <= '0;
            if ((state_q == LOCKED) && !err) begin
               frame_checksum <= sum_q;
               checksum_valid <= 1'b1;
            end
         end else if (pix_ok) begin
            sum_q <= sum_q + {4'b0000, r_q, g_q, b_q};
         end
      end
   end
`endif

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the VGA timing generator: samples a 640x480@60 VGA stream (hsync, vsync, 4-bit RGB) at the pixel rate.
- Checks horizontal and vertical timing against the standard and locks after consecutive clean frames.
- Recovers x/y pixel coordinates and emits one valid-qualified pixel per visible position.
- Used in loopback self-test (generator outputs wired back in) and as the front end of a future capture path.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate strobe; one clk cycle per pixel (every 2nd clk for the halved VGA clock)
- hsync_in  in  1  horizontal sync, active low
- vsync_in  in  1  vertical sync, active low
- red_in, green_in, blue_in  in  4 each  pixel colour
- locked  out  1  timing verified
- x  out  10  recovered column, 0..639
- y  out  10  recovered row, 0..479
- pixel_valid  out  1  one-clk pulse: x, y and pixel_* are valid
- pixel_r, pixel_g, pixel_b  out  4 each  captured colour
- frame_start  out  1  one-clk pulse on each vsync falling edge
- timing_error  out  1  one-clk pulse on any timing violation

Behaviour:
- **Clock and reset:** one clock, clk; reset is synchronous and active-high.
- **Reset values:** all outputs 0; state SEARCH; all counters 0; input registers at 1 for syncs and 0 for colour.
- **Sampling:** all inputs are registered only on clk edges with pix_en=1. Edge detection compares the current registered sync with the previous registered sync.
- **H counter (hcnt, 10 b):** counts pix_en strobes.
  - Reset to 0 on the sample where a hsync falling edge is seen; otherwise incremented.
  - H_TOTAL = 800.
  - At each hsync fall, the completed line length (hcnt+1) must equal H_TOTAL, else error.
  - At hsync rise, the low width must equal H_SYNC, else error.
  - hcnt saturates at 1023, which also counts as an error when the next fall arrives.
- **V counter (vcnt, 10 b):** incremented on each hsync fall; reset to 0 on the hsync fall coincident with or first after a vsync fall.
  - V_TOTAL = 525.
  - At vsync fall, the completed frame length must equal V_TOTAL.
  - The vsync low width must equal V_SYNC lines.
- **Visible window:** hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] = [144, 783], and vcnt in [35, 514].
  - x = hcnt-144, y = vcnt-35.
- **Pixel latency:** a colour sampled at pix_en strobe k appears on pixel_* with x/y at the strobe k+1 register update. pixel_valid is high for that single clk cycle only.
- **pixel_valid gating:** asserted only when locked=1 and the position is inside the visible window.
- **FSM:**
  - SEARCH: waits for a vsync fall, then goes to TRAIN with good=0. Errors are ignored and timing_error is not pulsed.
  - TRAIN: at each vsync fall, if the frame was error-free then good++, else good=0. When good reaches LOCK_FRAMES, go to LOCKED. Any error mid-frame returns to SEARCH and pulses timing_error.
  - LOCKED: locked=1. Any error pulses timing_error, goes to SEARCH, and drops locked the same cycle. No pixel_valid is emitted after the error.
- **Simultaneous hsync and vsync fall:** vcnt resets to 0 (it does not increment). The frame check uses the pre-reset count.
- **pix_en=0:** nothing changes and there are no pulses.
- **Reset mid-frame:** everything returns to reset values, and a full re-lock (LOCK_FRAMES+1 vsync falls) is required.

Optional Feature:
- Macro: VGA_RX_CHECKSUM_EN.
- **Defined:** adds ports frame_checksum (out, 16) and checksum_valid (out, 1).
  - A 16-bit wrap-around sum accumulates the 12-bit {r,g,b} of every pixel_valid pixel.
  - At each vsync fall while locked, the sum is copied to frame_checksum, checksum_valid pulses for 1 clk, and the accumulator clears.
  - Reset value of both ports is 0.
- **Undefined:** neither port exists and there is no accumulator logic.

Decomposition:
- **Package vga_timing_pkg:** H_/V_ default constants, derived H_TOTAL/V_TOTAL/H_START/V_START, and the typedef enum rx_state_t {SEARCH, TRAIN, LOCKED}. The generator side shares the same package.
- **Sub-module vga_axis_checker:**
  - Inputs: count enable, sync-fall, sync-rise.
  - Parameters: TOTAL, SYNC_W.
  - Outputs: count and a length/width error pulse.
  - Instantiated once for horizontal (enable = pix_en) and once for vertical (enable = hsync fall).

Test Plan:
- Reset, then drive 3 nominal 800x525 frames from a model generator with pix_en every 2nd clk -> locked rises at the 3rd vsync fall; timing_error never pulses.
- Locked, with pixel colour = x[3:0] on red -> first pixel_valid of a frame has x=0, y=0, pixel_r=0; the pixel at x=639, y=479 has pixel_r=15; exactly 307200 pixel_valid pulses per frame.
- Locked, one line shortened to 799 pixels -> timing_error pulses once at that hsync fall; locked falls the same cycle; no pixel_valid until re-locked 3 vsync falls later.
- hsync low width 95 instead of 96 during TRAIN -> timing_error pulse, state SEARCH, good counter cleared.
- Assert reset at line 200 of a locked frame -> next cycle all outputs 0 and locked=0; re-locks after 3 vsync falls.
- With VGA_RX_CHECKSUM_EN and constant colour 12'h001 -> checksum_valid pulses with frame_checksum = 307200 mod 65536 = 16'hB000.
